// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, load FSM states and ROM slicing for the FIR coefficient bank
package fir_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_COMMIT,
        ST_ERR
    } ld_state_t;

    // Number of unique coefficients actually stored and driven
    function automatic int coe_taps_true(input int taps, input int symmetry);
        return (symmetry != 0) ? (taps + taps % 2) / 2 : taps;
    endfunction

    // ceil(log2(n)), never below 1 so every index has at least one bit
    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        for (int k = 0; k < 32; k++) begin
            if ((1 << r) < n) r++;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // MSB position of set s, tap i inside the packed ROM image (set 0 tap 0 at the top)
    function automatic int rom_msb(input int s, input int i, input int rom_num,
                                   input int taps, input int width);
        return ((rom_num - s) * taps - i) * width - 1;
    endfunction

endpackage

// File: rtl/fir_coe_loader.sv
// rtl/fir_coe_loader.sv - framed coefficient load stream, staging and atomic commit strobe
module fir_coe_loader
    import fir_pkg::*;
#(
    parameter int COE_WIDTH     = 16,
    parameter int COE_TAPS_TRUE = 8,
    parameter int RAM_IDX_W     = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [RAM_IDX_W-1:0]               wr_bank_i,
    input  logic                               wr_vld_i,
    input  logic [COE_WIDTH-1:0]               wr_data_i,
    input  logic                               wr_last_i,
    output logic                               wr_rdy_o,
    output logic                               wr_err_o,
    output logic                               commit_o,
    output logic [RAM_IDX_W-1:0]               commit_bank_o,
    output logic [COE_WIDTH*COE_TAPS_TRUE-1:0] stage_o
);

    localparam int IDX_W = clog2_min1(COE_TAPS_TRUE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(COE_TAPS_TRUE - 1);

    ld_state_t            state;
    logic [IDX_W-1:0]     cnt;
    logic [COE_WIDTH-1:0] stage_q [COE_TAPS_TRUE];

    for (genvar g = 0; g < COE_TAPS_TRUE; g++) begin : g_stage
        assign stage_o[g*COE_WIDTH +: COE_WIDTH] = stage_q[g];
    end

    // Load FSM: a frame must end exactly on the last unique tap; anything else is discarded
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            commit_bank_o <= '0;
            wr_rdy_o      <= 1'b1;
            wr_err_o      <= 1'b0;
            commit_o      <= 1'b0;
            for (int i = 0; i < COE_TAPS_TRUE; i++) stage_q[i] <= '0;
        end else begin
            wr_err_o <= 1'b0;
            commit_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (wr_vld_i) begin
                        stage_q[0]    <= wr_data_i;
                        commit_bank_o <= wr_bank_i;
                        cnt           <= IDX_W'(1);
                        if ((COE_TAPS_TRUE == 1) ? !wr_last_i : wr_last_i) begin
                            state    <= ST_ERR;
                            wr_rdy_o <= 1'b0;
                            wr_err_o <= 1'b1;
                        end else if (COE_TAPS_TRUE == 1) begin
                            state    <= ST_COMMIT;
                            wr_rdy_o <= 1'b0;
                            commit_o <= 1'b1;
                        end else begin
                            state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (wr_vld_i) begin
                        stage_q[cnt] <= wr_data_i;
                        if (cnt == LAST_IDX) begin
                            wr_rdy_o <= 1'b0;
                            if (wr_last_i) begin
                                state    <= ST_COMMIT;
                                commit_o <= 1'b1;
                            end else begin
                                state    <= ST_ERR;
                                wr_err_o <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt + IDX_W'(1);
                            if (wr_last_i) begin
                                state    <= ST_ERR;
                                wr_rdy_o <= 1'b0;
                                wr_err_o <= 1'b1;
                            end
                        end
                    end
                end
                ST_COMMIT: begin
                    state    <= ST_IDLE;
                    wr_rdy_o <= 1'b1;
                end
                default: begin
                    for (int i = 0; i < COE_TAPS_TRUE; i++) stage_q[i] <= '0;
                    state    <= ST_IDLE;
                    wr_rdy_o <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/fir_coe_bank.sv
// rtl/fir_coe_bank.sv - ROM/RAM coefficient sets with sample-aligned set switching
module fir_coe_bank
    import fir_pkg::*;
#(
    parameter int COE_WIDTH    = 16,
    parameter int COE_TAPS     = 8,
    parameter int COE_SYMMETRY = 0,
    parameter int ROM_NUM      = 2,
    parameter int RAM_NUM      = 2,
    parameter int SEL_WIDTH    = clog2_min1(ROM_NUM + RAM_NUM),
    parameter int RAM_IDX_W    = clog2_min1(RAM_NUM),
    parameter logic [COE_WIDTH*COE_TAPS*ROM_NUM-1:0] COE_FILE = '0,
    localparam int COE_TAPS_TRUE = coe_taps_true(COE_TAPS, COE_SYMMETRY)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               coe_sel_vld_i,
    input  logic [SEL_WIDTH-1:0]               coe_sel_index_i,
    input  logic                               sample_vld_i,
    input  logic [RAM_IDX_W-1:0]               wr_bank_i,
    input  logic                               wr_vld_i,
    input  logic [COE_WIDTH-1:0]               wr_data_i,
    input  logic                               wr_last_i,
    output logic                               wr_rdy_o,
    output logic [COE_WIDTH*COE_TAPS_TRUE-1:0] coe_o,
    output logic [SEL_WIDTH-1:0]               coe_index_o,
    output logic                               sel_pending_o,
    output logic                               wr_err_o,
    output logic                               sel_err_o
);

    localparam int VEC_W = COE_WIDTH * COE_TAPS_TRUE;

    logic [VEC_W-1:0]     rom_vec [ROM_NUM];
    logic [VEC_W-1:0]     ram_q   [RAM_NUM];
    logic [VEC_W-1:0]     stage_vec;
    logic [VEC_W-1:0]     set_vec;
    logic [RAM_IDX_W-1:0] commit_bank;
    logic                 commit;
    logic [SEL_WIDTH-1:0] pend_idx;
    logic [SEL_WIDTH-1:0] eff_sel;
    logic                 in_range;
    logic                 sel_ok;
    logic                 swap;

    for (genvar s = 0; s < ROM_NUM; s++) begin : g_rom_set
        for (genvar i = 0; i < COE_TAPS_TRUE; i++) begin : g_rom_tap
            assign rom_vec[s][i*COE_WIDTH +: COE_WIDTH] =
                COE_FILE[rom_msb(s, i, ROM_NUM, COE_TAPS, COE_WIDTH) -: COE_WIDTH];
        end
    end

    fir_coe_loader #(
        .COE_WIDTH    (COE_WIDTH),
        .COE_TAPS_TRUE(COE_TAPS_TRUE),
        .RAM_IDX_W    (RAM_IDX_W)
    ) u_loader (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_bank_i    (wr_bank_i),
        .wr_vld_i     (wr_vld_i),
        .wr_data_i    (wr_data_i),
        .wr_last_i    (wr_last_i),
        .wr_rdy_o     (wr_rdy_o),
        .wr_err_o     (wr_err_o),
        .commit_o     (commit),
        .commit_bank_o(commit_bank),
        .stage_o      (stage_vec)
    );

    assign in_range = int'(coe_sel_index_i) < (ROM_NUM + RAM_NUM);
    assign sel_ok   = coe_sel_vld_i && in_range;
    assign eff_sel  = sel_ok ? coe_sel_index_i : pend_idx;
    assign swap     = sample_vld_i && (sel_ok || sel_pending_o);

    // Mux the set being swapped in; RAM sets are read before any same-cycle commit lands
    always_comb begin
        set_vec = rom_vec[0];
        for (int s = 0; s < ROM_NUM; s++) begin
            if (int'(eff_sel) == s) set_vec = rom_vec[s];
        end
        for (int r = 0; r < RAM_NUM; r++) begin
            if (int'(eff_sel) == ROM_NUM + r) set_vec = ram_q[r];
        end
    end

    // Writable sets: start as ROM set 0, replaced whole on a committed load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < RAM_NUM; r++) ram_q[r] <= rom_vec[0];
        end else if (commit) begin
            for (int r = 0; r < RAM_NUM; r++) begin
                if (int'(commit_bank) == r) ram_q[r] <= stage_vec;
            end
        end
    end

    // Pending select and tap output register; the taps only move on a sample strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coe_o         <= rom_vec[0];
            coe_index_o   <= '0;
            pend_idx      <= '0;
            sel_pending_o <= 1'b0;
            sel_err_o     <= 1'b0;
        end else begin
            sel_err_o <= coe_sel_vld_i && !in_range;
            if (swap) begin
                coe_o         <= set_vec;
                coe_index_o   <= eff_sel;
                sel_pending_o <= 1'b0;
            end else if (sel_ok) begin
                pend_idx      <= coe_sel_index_i;
                sel_pending_o <= 1'b1;
            end
        end
    end

endmodule
